// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM burst reader and its skid buffer.
package lstm_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int RAM_RD_LATENCY = 1;
    localparam int SKID_DEPTH     = 2;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, RAM-port and output-stream signals of the burst reader.
// The master modport is the reader's view; slave is the surrounding system.
interface ram_stream_reader_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) ();
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LEN_WIDTH  = $clog2(DEPTH) + 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  ram_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0]      ram_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [WIDTH-1:0]      m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_dout, m_ready,
        output cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_dout, m_ready,
        input  cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/ram_stream_reader_skid_fifo.sv
// Two-entry register FIFO holding {last, data} words returned by the RAM.
// Head is presented combinationally so the stream output needs no extra cycle.
module ram_rd_skid_fifo
    import lstm_ram_pkg::*;
#(
    parameter int DATA_W = 33
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_push,
    input  logic [DATA_W-1:0]                   i_push_data,
    input  logic                                i_pop,
    output logic [$clog2(SKID_DEPTH+1)-1:0]     o_count,
    output logic [DATA_W-1:0]                   o_head
);
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    logic [DATA_W-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: turns an (addr, len) command into sequential RAM reads and a
// backpressured stream with a last flag, never holding more than two words.
module ram_stream_reader
    import lstm_ram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_stream_reader_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LEN_WIDTH  = $clog2(DEPTH) + 1;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int SLOT_W     = CNT_W + 1;
    localparam int SUM_W      = LEN_WIDTH + 1;
    localparam logic [SUM_W-1:0] DEPTH_EXT = SUM_W'(DEPTH);

    rd_state_e             r_state;
    rd_state_e             w_state_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_pushed;
    logic [LEN_WIDTH-1:0]  r_popped;
    logic                  r_inflight;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_m_valid;
    logic                  w_push_last;
    logic [SLOT_W-1:0]     w_slots_used;
    logic [SUM_W-1:0]      w_addr_sum;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [WIDTH:0]        w_fifo_head;

    assign w_accept  = bus.cmd_valid && (r_state == IDLE);
    assign w_m_valid = (w_fifo_count != '0);
    assign w_pop     = w_m_valid && bus.m_ready;

    // A read may only go out if its word is certain to find a FIFO slot,
    // counting the word already on its way back and any pop this cycle.
    assign w_slots_used = SLOT_W'(w_fifo_count) + SLOT_W'(r_inflight) - SLOT_W'(w_pop);
    assign w_issue      = (r_state == READ) && (r_issued != r_len)
                       && (w_slots_used < SLOT_W'(SKID_DEPTH));

    assign w_addr_sum  = SUM_W'(r_base) + SUM_W'(r_issued);
    assign w_rd_addr   = (w_addr_sum >= DEPTH_EXT) ? ADDR_WIDTH'(w_addr_sum - DEPTH_EXT)
                                                   : ADDR_WIDTH'(w_addr_sum);
    assign w_push_last = (r_pushed == r_len - LEN_WIDTH'(1));

    always_comb begin
        w_state_next  = r_state;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.ram_en    = w_issue;
        bus.ram_addr  = w_issue ? w_rd_addr : '0;
        bus.m_valid   = w_m_valid;
        bus.m_data    = w_fifo_head[WIDTH-1:0];
        bus.m_last    = w_m_valid && w_fifo_head[WIDTH];
        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    w_state_next = (bus.cmd_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (w_issue && (r_issued + LEN_WIDTH'(1) == r_len)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && (r_popped + LEN_WIDTH'(1) == r_len)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                bus.done     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_pushed   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            if (w_accept) begin
                r_base   <= bus.cmd_addr;
                r_len    <= bus.cmd_len;
                r_issued <= '0;
                r_pushed <= '0;
                r_popped <= '0;
            end else begin
                if (w_issue)    r_issued <= r_issued + LEN_WIDTH'(1);
                if (r_inflight) r_pushed <= r_pushed + LEN_WIDTH'(1);
                if (w_pop)      r_popped <= r_popped + LEN_WIDTH'(1);
            end
        end
    end

    // Clearing r_inflight on reset is what discards a read still in flight.
    ram_rd_skid_fifo #(
        .DATA_W (WIDTH + 1)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data ({w_push_last, bus.ram_dout}),
        .i_pop       (w_pop),
        .o_count     (w_fifo_count),
        .o_head      (w_fifo_head)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model preloaded with i+100, table of bursts,
// scoreboard of expected addresses and beats, plus reset and back-to-back cases.
module tb_ram_stream_reader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH-1:0] ram_mem [DEPTH];
    logic [WIDTH-1:0] ram_q;
    always @(posedge clk) if (bus.ram_en) ram_q <= ram_mem[bus.ram_addr];
    assign bus.ram_dout = ram_q;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    typedef struct {
        int          addr;
        int          len;
        int          mode;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    beat_t      exp_q [$];
    logic [7:0] addr_q [$];
    vec_t       vecs [6];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int burst_id = 0;
    int seen_id  = 0;

    int beats = 0, n_en = 0, n_valid = 0, last_idx = -1;
    int first_en_cyc = -1, last_en_cyc = -1, first_v_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
    logic [31:0] first_data = '0, last_data = '0, prev_data = '0;
    logic prev_stall = 1'b0, prev_last = 1'b0, prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return (k > 12) && (((k - 13) % 2) == 0);
        endcase
    endfunction

    // Monitor: samples on the falling edge, between the driving and active edges.
    always @(negedge clk) begin
        beat_t      b;
        logic [7:0] a;
        if (burst_id != seen_id) begin
            seen_id = burst_id;
            beats = 0; n_en = 0; n_valid = 0; last_idx = -1;
            first_en_cyc = -1; last_en_cyc = -1; first_v_cyc = -1;
            last_beat_cyc = -1; done_cyc = -1;
            first_data = '0; last_data = '0;
        end
        if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.m_valid), 64'(1));
                chk("hold_data", 64'(bus.m_data), 64'(prev_data));
                chk("hold_last", 64'(bus.m_last), 64'(prev_last));
            end
            if (bus.ram_en) begin
                n_en++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
                chk("read_expected", 64'(addr_q.size() != 0), 64'(1));
                if (addr_q.size() != 0) begin
                    a = addr_q.pop_front();
                    chk("ram_addr", 64'(bus.ram_addr), 64'(a));
                end
            end
            if (bus.m_valid) begin
                n_valid++;
                if (first_v_cyc < 0) first_v_cyc = cyc;
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    chk("m_data", 64'(bus.m_data), 64'(b.data));
                    chk("m_last", 64'(bus.m_last), 64'(b.last));
                end
                if (beats == 0) first_data = bus.m_data;
                if (bus.m_last) begin
                    last_data = bus.m_data;
                    last_idx  = beats;
                end
                beats++;
                last_beat_cyc = cyc;
            end
            if (bus.done) begin
                chk("done_one_cycle", 64'(prev_done), 64'(0));
                chk("cmd_ready_in_done", 64'(bus.cmd_ready), 64'(0));
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            prev_done  = bus.done;
        end
    end

    task automatic push_expect(input int addr, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{last: (i == len - 1), data: 32'(((addr + i) % DEPTH) + 100)});
            addr_q.push_back(8'((addr + i) % DEPTH));
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst_ram_en", 64'(bus.ram_en), 64'(0));
        chk("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
        chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
        chk("rst_m_data", 64'(bus.m_data), 64'(0));
        chk("rst_m_last", 64'(bus.m_last), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
    endtask

    // Entered and left just after a rising edge; the command is offered at once.
    task automatic run_burst(input int addr, input int len, input int mode,
                             input logic [31:0] exp_first, input logic [31:0] exp_last);
        int acc;
        int bound;
        burst_id++;
        push_expect(addr, len);
        chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 8'(addr);
        bus.cmd_len   = 9'(len);
        bus.m_ready   = ready_for(mode, 0);
        acc   = cyc;
        bound = len * 4 + 40;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            if (mode == 3 && k == 13) chk("stall_reads", 64'(n_en), 64'(2));
            if (done_cyc >= 0) break;
            bus.m_ready = ready_for(mode, k);
        end
        chk("done_seen", 64'(done_cyc >= 0), 64'(1));
        chk("cmd_ready_after_done", 64'(bus.cmd_ready), 64'(1));
        chk("beats", 64'(beats), 64'(len));
        chk("reads", 64'(n_en), 64'(len));
        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        if (len == 0) begin
            chk("len0_valid", 64'(n_valid), 64'(0));
            chk("len0_done", 64'(done_cyc), 64'(acc + 1));
        end else begin
            chk("first_data", 64'(first_data), 64'(exp_first));
            chk("last_data", 64'(last_data), 64'(exp_last));
            chk("last_index", 64'(last_idx), 64'(len - 1));
            chk("done_after_last", 64'(done_cyc), 64'(last_beat_cyc + 1));
            if (mode == 0) begin
                chk("first_read_lat", 64'(first_en_cyc), 64'(acc + 1));
                chk("first_valid_lat", 64'(first_v_cyc), 64'(acc + 3));
                chk("read_span", 64'(last_en_cyc - first_en_cyc), 64'(len - 1));
                chk("beat_span", 64'(last_beat_cyc - first_v_cyc), 64'(len - 1));
            end
        end
        $display("burst addr=%0d len=%0d mode=%0d accept=%0d beats=%0d done=%0d first=%0d last=%0d",
                 addr, len, mode, acc, beats, done_cyc, first_data, last_data);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = 32'(i + 100);
        vecs[0] = '{addr: 10,  len: 4,  mode: 0, exp_first: 110, exp_last: 113};
        vecs[1] = '{addr: 254, len: 4,  mode: 0, exp_first: 354, exp_last: 101};
        vecs[2] = '{addr: 40,  len: 8,  mode: 3, exp_first: 140, exp_last: 147};
        vecs[3] = '{addr: 7,   len: 0,  mode: 0, exp_first: 0,   exp_last: 0};
        vecs[4] = '{addr: 250, len: 12, mode: 2, exp_first: 350, exp_last: 105};
        vecs[5] = '{addr: 100, len: 3,  mode: 1, exp_first: 200, exp_last: 202};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].mode, vecs[v].exp_first, vecs[v].exp_last);
        end

        // Full-depth burst followed immediately by a single-word burst.
        run_burst(0, DEPTH, 0, 100, 355);
        run_burst(5, 1, 0, 105, 105);

        // Reset after three beats of an eight-word burst.
        burst_id++;
        push_expect(20, 8);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 8'd20;
        bus.cmd_len   = 9'd8;
        bus.m_ready   = 1'b1;
        for (int k = 0; k < 40 && beats < 3; k++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
        end
        chk("beats_before_reset", 64'(beats), 64'(3));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        $display("reset mid-burst applied at cycle %0d", cyc);
        @(posedge clk); #1;
        run_burst(0, 2, 0, 100, 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
